// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> mul/div sequencer handshake bundle.
// master = execute stage, slave = sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, word, rs1, rs2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, word, rs1, rs2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide sequencer: shift-add multiply and restoring
// divide, one bit per cycle, with divide-by-zero/overflow resolved in one cycle.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  logic [2:0]      op_r;
  logic            word_r;
  logic            neg_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] result_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  // Accept-time operand preparation
  logic [2:0]      eff_op;
  logic            signed_a, signed_b, sa, sb, is_div;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
  logic            div_zero, div_ovf, special, neg_in;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    // Word-width high-half multiplies collapse onto MULW
    eff_op   = (bus.word && !bus.op[2]) ? 3'b000 : bus.op;
    is_div   = eff_op[2];
    signed_a = eff_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    signed_b = eff_op inside {3'b000, 3'b001, 3'b100, 3'b110};
    a_ext    = bus.rs1;
    b_ext    = bus.rs2;
    if (bus.word) begin
      a_ext = signed_a ? sext32(bus.rs1[31:0]) : zext32(bus.rs1[31:0]);
      b_ext = signed_b ? sext32(bus.rs2[31:0]) : zext32(bus.rs2[31:0]);
    end
    sa     = signed_a & a_ext[XLEN-1];
    sb     = signed_b & b_ext[XLEN-1];
    mag_a  = sa ? -a_ext : a_ext;
    mag_b  = sb ? -b_ext : b_ext;
    neg_in = (is_div && eff_op[1]) ? sa : (sa ^ sb);

    div_zero = is_div && (bus.word ? (bus.rs2[31:0] == '0) : (bus.rs2 == '0));
    div_ovf  = is_div && !eff_op[0] &&
               (bus.word ? (bus.rs1[31:0] == 32'h8000_0000 && bus.rs2[31:0] == '1)
                         : (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2 == '1));
    special  = div_zero || div_ovf;

    spec_res = '0;
    if (div_zero)
      spec_res = eff_op[1] ? (bus.word ? sext32(bus.rs1[31:0]) : bus.rs1) : '1;
    else if (div_ovf)
      spec_res = eff_op[1] ? '0 : (bus.word ? sext32(bus.rs1[31:0]) : bus.rs1);
  end

  // One iteration of either algorithm on the hi:lo pair
  logic [XLEN:0]   mul_sum, rem_s, diff;
  logic [XLEN-1:0] mul_hi, mul_lo, div_hi, div_lo;

  always_comb begin
    mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : '0);
    mul_hi  = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_r[XLEN-1:1]};
    rem_s   = {hi_r, lo_r[XLEN-1]};
    diff    = rem_s - {1'b0, a_r};
    if (!diff[XLEN]) begin
      div_hi = diff[XLEN-1:0];
      div_lo = {lo_r[XLEN-2:0], 1'b1};
    end else begin
      div_hi = rem_s[XLEN-1:0];
      div_lo = {lo_r[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection; word multiplies leave the product
  // scaled by 2^(XLEN-32), so their 32 result bits sit at the top of lo.
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   quo_f, rem_f, fin_res;

  always_comb begin
    prod_f = neg_r ? -{hi_r, lo_r} : {hi_r, lo_r};
    quo_f  = neg_r ? -lo_r : lo_r;
    rem_f  = neg_r ? -hi_r : hi_r;
    case (op_r)
      3'b000:                 fin_res = word_r ? sext32(prod_f[XLEN-1 -: 32]) : prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = word_r ? sext32(quo_f[31:0]) : quo_f;
      default:                fin_res = word_r ? sext32(rem_f[31:0]) : rem_f;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_r        <= '0;
      word_r      <= 1'b0;
      neg_r       <= 1'b0;
      a_r         <= '0;
      hi_r        <= '0;
      lo_r        <= '0;
      cnt_r       <= '0;
      result_r    <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (bus.flush) begin
      state       <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_r       <= eff_op;
            word_r     <= bus.word;
            neg_r      <= neg_in;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            hi_r       <= '0;
            cnt_r      <= bus.word ? CW'(32) : CW'(XLEN);
            if (is_div) begin
              a_r  <= mag_b;
              lo_r <= bus.word ? (mag_a << (XLEN - 32)) : mag_a;
            end else begin
              a_r  <= mag_a;
              lo_r <= mag_b;
            end
            if (special) begin
              result_r    <= spec_res;
              out_valid_r <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
            hi_r  <= op_r[2] ? div_hi : mul_hi;
            lo_r  <= op_r[2] ? div_lo : mul_lo;
          end else begin
            result_r    <= fin_res;
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(64)) bus ();

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  // Drives one request, waits for the result and consumes it.
  task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    bus.op = o; bus.word = w; bus.rs1 = a; bus.rs2 = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin lat = i; break; end
    end
    res = bus.result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_cmp++; if (bus.result !== 64'h0) begin n_bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
  endtask

  task automatic test_mul_timing;
    int lat, viol, unstable;
    logic [63:0] first;
    lat = -1; viol = 0; unstable = 0;
    bus.op = OP_MUL; bus.word = 1'b0; bus.rs1 = 64'd7; bus.rs2 = -64'sd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin lat = i; break; end
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) viol++;
    end
    n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL mul_latency got=%0d want=65", lat); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL mul_busy_stall got=%0d bad cycles want=0", viol); end
    first = bus.result;
    n_cmp++; if (first !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL mul_result got=%h want=ffffffffffffffeb", first); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.result !== 64'hFFFF_FFFF_FFFF_FFEB) unstable++;
    end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL hold_stable got=%0d unstable cycles want=0", unstable); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_before_take got=%b want=0", bus.in_ready); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_after_take got=%b want=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_take got ov=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_mul_high;
    logic [63:0] r; int lat;
    do_op(OP_MULHU, 1'b0, '1, '1, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 65) begin n_bad++; $display("FAIL mulhu got=%h lat=%0d want=fffffffffffffffe lat=65", r, lat); end
    do_op(OP_MULH, 1'b0, '1, '1, r, lat);
    n_cmp++; if (r !== 64'h0) begin n_bad++; $display("FAIL mulh got=%h want=0", r); end
    do_op(OP_MULHSU, 1'b0, '1, 64'd2, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL mulhsu got=%h want=ffffffffffffffff", r); end
  endtask

  task automatic test_div;
    logic [63:0] r; int lat;
    do_op(OP_DIV, 1'b0, -64'sd7, 64'd2, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 65) begin n_bad++; $display("FAIL div got=%h lat=%0d want=fffffffffffffffd lat=65", r, lat); end
    do_op(OP_REM, 1'b0, -64'sd7, 64'd2, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL rem got=%h want=ffffffffffffffff", r); end
    do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, r, lat);
    n_cmp++; if (r !== 64'd14) begin n_bad++; $display("FAIL divu got=%h want=e", r); end
    do_op(OP_REMU, 1'b0, 64'd100, 64'd7, r, lat);
    n_cmp++; if (r !== 64'd2) begin n_bad++; $display("FAIL remu got=%h want=2", r); end
  endtask

  task automatic test_special;
    logic [63:0] r; int lat;
    do_op(OP_DIVU, 1'b0, 64'd5, 64'd0, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 1) begin n_bad++; $display("FAIL divu_by0 got=%h lat=%0d want=ffffffffffffffff lat=1", r, lat); end
    do_op(OP_REM, 1'b0, 64'd5, 64'd0, r, lat);
    n_cmp++; if (r !== 64'd5 || lat !== 1) begin n_bad++; $display("FAIL rem_by0 got=%h lat=%0d want=5 lat=1", r, lat); end
    do_op(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, r, lat);
    n_cmp++; if (r !== 64'h8000_0000_0000_0000 || lat !== 1) begin n_bad++; $display("FAIL div_ovf got=%h lat=%0d want=8000000000000000 lat=1", r, lat); end
    do_op(OP_REM, 1'b0, 64'h8000_0000_0000_0000, '1, r, lat);
    n_cmp++; if (r !== 64'h0 || lat !== 1) begin n_bad++; $display("FAIL rem_ovf got=%h lat=%0d want=0 lat=1", r, lat); end
    do_op(OP_DIV, 1'b1, 64'h0000_0000_8000_0000, '1, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_8000_0000 || lat !== 1) begin n_bad++; $display("FAIL divw_ovf got=%h lat=%0d want=ffffffff80000000 lat=1", r, lat); end
  endtask

  task automatic test_word;
    logic [63:0] r; int lat;
    do_op(OP_MUL, 1'b1, 64'h1_0000_0003, 64'h4000_0000, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_C000_0000 || lat !== 33) begin n_bad++; $display("FAIL mulw got=%h lat=%0d want=ffffffffc0000000 lat=33", r, lat); end
    do_op(OP_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd2, r, lat);
    n_cmp++; if (r !== 64'h7FFF_FFFF || lat !== 33) begin n_bad++; $display("FAIL divuw got=%h lat=%0d want=7fffffff lat=33", r, lat); end
    do_op(OP_REM, 1'b1, -64'sd7, 64'd2, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL remw got=%h want=ffffffffffffffff", r); end
    do_op(OP_MULHU, 1'b1, 64'h5, 64'hFFFF_FFFF, r, lat);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFB || lat !== 33) begin n_bad++; $display("FAIL mulhuw_as_mulw got=%h lat=%0d want=fffffffffffffffb lat=33", r, lat); end
  endtask

  task automatic test_flush;
    int seen;
    seen = 0;
    bus.op = OP_MUL; bus.word = 1'b0; bus.rs1 = 64'd9; bus.rs2 = 64'd9; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_busy got busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready); end
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_result got=%0d valid cycles want=0", seen); end
    bus.flush = 1'b1; bus.op = OP_DIVU; bus.rs1 = 64'd5; bus.rs2 = 64'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_idle_accept got busy=%b ov=%b want 0/0", bus.busy, bus.out_valid); end
  endtask

  task automatic test_reset_mid;
    bus.op = OP_DIVU; bus.word = 1'b0; bus.rs1 = 64'd1000; bus.rs2 = 64'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_before_reset got=%b want=1", bus.busy); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL async_reset got in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [63:0] r1, r2; int l1, l2;
    do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, r1, l1);
    do_op(OP_MUL, 1'b0, 64'h1_0000_0000, 64'h1_0000_0001, r2, l2);
    n_cmp++; if (r1 !== 64'd14 || l1 !== 65) begin n_bad++; $display("FAIL b2b_first got=%h lat=%0d want=e lat=65", r1, l1); end
    n_cmp++; if (r2 !== 64'h0000_0001_0000_0000 || l2 !== 65) begin n_bad++; $display("FAIL b2b_second got=%h lat=%0d want=100000000 lat=65", r2, l2); end
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0; bus.word = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_mul_timing;
    test_mul_high;
    test_div;
    test_special;
    test_word;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
